// File: rtl/io_bus_pkg.sv
// Shared constants and FSM state encoding for the IO bus arbiter.
package io_bus_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester above ptr,
// wrapping, so the last owner has the lowest priority.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = PTR_W'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin sharing of one IO port between N requesters, sequencing each
// access as SETUP -> ACCESS -> DONE, plus the IO interrupt handshake.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int N      = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                Clk,
  input  logic                Reset_,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        we,
  input  logic [N*ADDR_W-1:0] addr,
  input  logic [N*DATA_W-1:0] wdata,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        done,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   IO_Addr,
  inout  wire  [DATA_W-1:0]   IO_Data,
  output logic                IO_CS_,
  output logic                IO_RD_,
  output logic                IO_WR_,
  input  logic                io_int,
  output logic                io_int_ack,
  output logic                cpu_int,
  input  logic                cpu_int_ack
);

  localparam int PTR_W = $clog2(N);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  io_addr_q, io_addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [N-1:0]       done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               cs_q, cs_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               oe_q, oe_d;
  logic               cpu_int_q, cpu_int_d;
  logic               io_int_ack_q, io_int_ack_d;

  logic [N-1:0]       win_gnt;
  logic [PTR_W-1:0]   win_idx;

  rr_arbiter #(.N(N)) u_rr (
    .req  (req),
    .ptr  (ptr_q),
    .grant(win_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win_gnt[i]) win_idx = PTR_W'(i);
    end
  end

  // Strobes and data enable are computed for the state being entered, so
  // the registered IO pins line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    we_d      = we_q;
    io_addr_d = io_addr_q;
    wdata_d   = wdata_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    cs_d      = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    oe_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = SETUP;
          owner_d   = win_idx;
          we_d      = we[win_idx];
          io_addr_d = addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d   = wdata[int'(win_idx)*DATA_W +: DATA_W];
          gnt_d     = win_gnt;
        end
      end
      SETUP: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          state_d = ACCESS;
          cs_d    = 1'b0;
          rd_d    = we_q;
          wr_d    = !we_q;
          oe_d    = we_q;
        end
      end
      ACCESS: begin
        state_d         = DONE;
        done_d[owner_q] = 1'b1;
        if (!we_q) rdata_d = IO_Data;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = owner_q;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Acknowledge beats a simultaneous new interrupt; a held io_int re-sets
  // cpu_int on the following edge.
  always_comb begin
    cpu_int_d    = cpu_int_q;
    io_int_ack_d = 1'b0;
    if (cpu_int_ack && cpu_int_q) begin
      cpu_int_d    = 1'b0;
      io_int_ack_d = 1'b1;
    end else if (io_int) begin
      cpu_int_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!Reset_) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      ptr_q        <= PTR_W'(N - 1);
      we_q         <= 1'b0;
      io_addr_q    <= '0;
      wdata_q      <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      cs_q         <= 1'b1;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      oe_q         <= 1'b0;
      cpu_int_q    <= 1'b0;
      io_int_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      we_q         <= we_d;
      io_addr_q    <= io_addr_d;
      wdata_q      <= wdata_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      oe_q         <= oe_d;
      cpu_int_q    <= cpu_int_d;
      io_int_ack_q <= io_int_ack_d;
    end
  end

  assign IO_Data    = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign IO_Addr    = io_addr_q;
  assign IO_CS_     = cs_q;
  assign IO_RD_     = rd_q;
  assign IO_WR_     = wr_q;
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign cpu_int    = cpu_int_q;
  assign io_int_ack = io_int_ack_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter with a simple IO memory model on the bus.
module tb_io_bus_arbiter;

  localparam int N      = 2;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic                Clk = 1'b0;
  logic                Reset_;
  logic [N-1:0]        req;
  logic [N-1:0]        we;
  logic [N*ADDR_W-1:0] addr;
  logic [N*DATA_W-1:0] wdata;
  logic [N-1:0]        gnt;
  logic [N-1:0]        done;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   IO_Addr;
  wire  [DATA_W-1:0]   io_data;
  logic                IO_CS_, IO_RD_, IO_WR_;
  logic                io_int, io_int_ack, cpu_int, cpu_int_ack;

  io_bus_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk        (Clk),
    .Reset_     (Reset_),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .done       (done),
    .rdata      (rdata),
    .IO_Addr    (IO_Addr),
    .IO_Data    (io_data),
    .IO_CS_     (IO_CS_),
    .IO_RD_     (IO_RD_),
    .IO_WR_     (IO_WR_),
    .io_int     (io_int),
    .io_int_ack (io_int_ack),
    .cpu_int    (cpu_int),
    .cpu_int_ack(cpu_int_ack)
  );

  always #5 Clk = ~Clk;

  // IO model: unwritten locations read back a fixed address-derived pattern.
  bit [DATA_W-1:0] mem      [0:(1<<ADDR_W)-1];
  bit              mem_vld  [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] mem_default(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    return mem_vld[a] ? mem[a] : mem_default(a);
  endfunction

  assign io_data = (!IO_CS_ && !IO_RD_) ? mem_read(IO_Addr) : {DATA_W{1'bz}};

  always @(posedge Clk) begin
    if (!IO_CS_ && !IO_WR_) begin
      mem[IO_Addr]     <= io_data;
      mem_vld[IO_Addr] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  typedef struct {
    int              idx;
    bit              is_rd;
    logic [DATA_W-1:0] data;
    int              exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_cnt   = 0;
  int   gnt_viol   = 0;
  int   z_viol     = 0;
  int   cs_low_cnt = 0;

  // Output monitor: pops one expectation per done pulse.
  always @(negedge Clk) begin
    exp_t e;
    if (|done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_owner", 64'(done), 64'(1 << e.idx));
        if (e.is_rd) check("rdata", 64'(rdata), 64'(e.data));
        if (e.exp_cyc >= 0) check("done_cycle", 64'(cyc), 64'(e.exp_cyc));
      end
    end
    if ($countones(gnt) > 1) gnt_viol++;
    if (IO_CS_ && (io_data !== {DATA_W{1'bz}})) z_viol++;
    if (!IO_CS_) cs_low_cnt++;
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic issue(input int i, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req[i]                  = 1'b1;
    we[i]                   = w;
    addr[i*ADDR_W +: ADDR_W] = a;
    wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_done(input int i, input bit rd, input logic [DATA_W-1:0] d,
                             input int c);
    exp_t e;
    e.idx = i; e.is_rd = rd; e.data = d; e.exp_cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("done_in_time", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic do_reset();
    Reset_ = 1'b0;
    req    = '0;
    repeat (3) tick();
    Reset_ = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, cs0, dc0, base;
    Reset_ = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    io_int = 1'b0; cpu_int_ack = 1'b0;

    // Reset dominates active requests and interrupt.
    req = '1; io_int = 1'b1;
    repeat (3) tick();
    check("rst_cs",   64'(IO_CS_), 64'd1);
    check("rst_rd",   64'(IO_RD_), 64'd1);
    check("rst_wr",   64'(IO_WR_), 64'd1);
    check("rst_dz",   64'(io_data === {DATA_W{1'bz}}), 64'd1);
    check("rst_gnt",  64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cint", 64'(cpu_int), 64'd0);
    check("rst_ack",  64'(io_int_ack), 64'd0);
    check("rst_addr", 64'(IO_Addr), 64'd0);
    check("rst_rdat", 64'(rdata), 64'd0);
    req = '0; io_int = 1'b0; Reset_ = 1'b1;
    tick();

    // Single write. Sequence is IDLE(sample), SETUP, ACCESS, DONE, so done
    // is visible after the third edge following the drive point.
    issue(0, 1'b1, 10'h3A5, 32'hDEAD_BEEF);
    expect_done(0, 1'b0, '0, cyc + 3);
    tick();
    addr[0 +: ADDR_W] = 10'h000;
    wdata[0 +: DATA_W] = '0;
    wait_done(1, 20);
    req = '0;
    tick();
    check("wr_commit", 64'(mem_read(10'h3A5)), 64'hDEAD_BEEF);
    check("wr_latched", 64'(mem_read(10'h000)), 64'(mem_default(10'h000)));

    issue(0, 1'b0, 10'h3A5, '0);
    expect_done(0, 1'b1, 32'hDEAD_BEEF, cyc + 3);
    wait_done(2, 20);
    req = '0;
    tick();
    issue(0, 1'b1, 10'h3A6, 32'h1234_5678);
    expect_done(0, 1'b0, '0, cyc + 3);
    wait_done(3, 20);
    req = '0;
    tick();
    check("rdata_hold", 64'(rdata), 64'hDEAD_BEEF);

    // Contention: requester 0 writes, requester 1 reads the same location.
    do_reset();
    base = done_cnt;
    issue(0, 1'b1, 10'h020, 32'h0000_1111);
    issue(1, 1'b0, 10'h020, '0);
    c = cyc;
    for (int j = 0; j < 8; j++) expect_done(j % 2, (j % 2) == 1, 32'h0000_1111, c + 3 + 4*j);
    wait_done(base + 8, 60);
    req = '0;
    repeat (3) tick();
    check("cont_drained", 64'(done_cnt), 64'(base + 8));

    // Abort: leaves pointer at 0 (last completed owner), so 1 wins next.
    base = done_cnt;
    issue(0, 1'b0, 10'h020, '0);
    expect_done(0, 1'b1, 32'h0000_1111, cyc + 3);
    wait_done(base + 1, 20);
    req = '0;
    tick();
    cs0 = cs_low_cnt;
    dc0 = done_cnt;
    issue(1, 1'b0, 10'h030, '0);
    tick();
    check("abort_gnt", 64'(gnt), 64'b10);
    check("abort_addr", 64'(IO_Addr), 64'h030);
    req = '0;
    tick();
    check("abort_gnt_clr", 64'(gnt), 64'd0);
    repeat (3) tick();
    check("abort_no_cs", 64'(cs_low_cnt), 64'(cs0));
    check("abort_no_done", 64'(done_cnt), 64'(dc0));
    issue(0, 1'b0, 10'h020, '0);
    issue(1, 1'b0, 10'h030, '0);
    c = cyc;
    expect_done(1, 1'b1, mem_default(10'h030), c + 3);
    expect_done(0, 1'b1, 32'h0000_1111, c + 7);
    wait_done(dc0 + 2, 30);
    req = '0;
    tick();

    // Reset during a read ACCESS.
    dc0 = done_cnt;
    issue(0, 1'b0, 10'h001, '0);
    tick();
    tick();
    check("mid_cs_low", 64'({IO_CS_, IO_RD_}), 64'd0);
    Reset_ = 1'b0;
    req = '0;
    tick();
    check("mid_strobes", 64'({IO_CS_, IO_RD_, IO_WR_}), 64'b111);
    check("mid_gnt", 64'(gnt), 64'd0);
    Reset_ = 1'b1;
    repeat (2) tick();
    check("mid_no_done", 64'(done_cnt), 64'(dc0));
    issue(0, 1'b0, 10'h001, '0);
    expect_done(0, 1'b1, mem_default(10'h001), cyc + 3);
    wait_done(dc0 + 1, 20);
    req = '0;
    tick();

    // Interrupt: single-cycle io_int is latched until acknowledged.
    io_int = 1'b1;
    tick();
    io_int = 1'b0;
    check("int_set", 64'(cpu_int), 64'd1);
    repeat (3) tick();
    check("int_hold", 64'({cpu_int, io_int_ack}), 64'b10);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    check("int_ack", 64'({cpu_int, io_int_ack}), 64'b01);
    tick();
    check("int_ack_pulse", 64'({cpu_int, io_int_ack}), 64'b00);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    check("int_stray_ack", 64'({cpu_int, io_int_ack}), 64'b00);

    // Held io_int: ack wins for one cycle, then the level re-asserts cpu_int.
    io_int = 1'b1;
    tick();
    check("lvl_set", 64'(cpu_int), 64'd1);
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    check("lvl_ack", 64'({cpu_int, io_int_ack}), 64'b01);
    tick();
    check("lvl_reassert", 64'({cpu_int, io_int_ack}), 64'b10);
    io_int = 1'b0;
    tick();

    check("gnt_onehot", 64'(gnt_viol), 64'd0);
    check("bus_z_idle", 64'(z_viol), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
